// File: rtl/countdown_timer.sv
// BCD mm:ss countdown engine with a one-second prescaler, decrement tick and
// time-up output that closes the loop with the run/stop toggle register.
module countdown_timer #(
   parameter int TICK_DIV = 50000000,
   parameter int PW       = $clog2(TICK_DIV)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       load,
   input  logic [7:0] load_mins,
   input  logic [7:0] load_secs,
   output logic [7:0] mins_bcd,
   output logic [7:0] secs_bcd,
   output logic       time_up,
   output logic       tick,
   output logic       zero
);

   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRE_ONE = PW'(1);

   logic [PW-1:0] pre;
   logic [7:0]    mins_dec;
   logic [7:0]    secs_dec;
   logic [7:0]    mins_clamped;
   logic [7:0]    secs_clamped;
   logic          dec_zero;
   logic          wrap;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
      return (d > lim) ? lim : d;
   endfunction

   assign mins_clamped = {clamp_digit(load_mins[7:4], 4'd9), clamp_digit(load_mins[3:0], 4'd9)};
   assign secs_clamped = {clamp_digit(load_secs[7:4], 4'd5), clamp_digit(load_secs[3:0], 4'd9)};

   assign zero     = (mins_bcd == 8'h00) && (secs_bcd == 8'h00);
   assign wrap     = (pre == PRE_MAX);
   assign dec_zero = (mins_dec == 8'h00) && (secs_dec == 8'h00);

   // BCD borrow chain: seconds units, seconds tens, then minutes with secs reset to 59.
   always_comb begin
      mins_dec = mins_bcd;
      secs_dec = secs_bcd;
      if (secs_bcd[3:0] != 4'd0) begin
         secs_dec[3:0] = secs_bcd[3:0] - 4'd1;
      end else if (secs_bcd[7:4] != 4'd0) begin
         secs_dec = {secs_bcd[7:4] - 4'd1, 4'd9};
      end else if (mins_bcd != 8'h00) begin
         secs_dec = 8'h59;
         if (mins_bcd[3:0] != 4'd0) begin
            mins_dec[3:0] = mins_bcd[3:0] - 4'd1;
         end else begin
            mins_dec = {mins_bcd[7:4] - 4'd1, 4'd9};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mins_bcd <= 8'h00;
         secs_bcd <= 8'h00;
         pre      <= '0;
         time_up  <= 1'b0;
         tick     <= 1'b0;
      end else if (load) begin
         mins_bcd <= mins_clamped;
         secs_bcd <= secs_clamped;
         pre      <= '0;
         time_up  <= 1'b0;
         tick     <= 1'b0;
      end else if (run) begin
         if (wrap) begin
            pre <= '0;
            if (!zero) begin
               mins_bcd <= mins_dec;
               secs_bcd <= secs_dec;
               tick     <= 1'b1;
               time_up  <= dec_zero;
            end else begin
               tick    <= 1'b0;
               time_up <= 1'b1;
            end
         end else begin
            pre     <= pre + PRE_ONE;
            tick    <= 1'b0;
            time_up <= zero;
         end
      end else begin
         // Paused: prescaler holds so the partial second survives.
         tick    <= 1'b0;
         time_up <= 1'b0;
      end
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICK_DIV=4, including a small
// toggle-register model to exercise the start/time-up loop.
module tb_countdown_timer;

   logic       clk;
   logic       rst;
   logic       run;
   logic       run_drv;
   logic       load;
   logic [7:0] load_mins;
   logic [7:0] load_secs;
   logic [7:0] mins_bcd;
   logic [7:0] secs_bcd;
   logic       time_up;
   logic       tick;
   logic       zero;

   logic       use_loop;
   logic       start;
   logic       run_tff;
   logic       time_up_d;

   int checks   = 0;
   int failures = 0;

   countdown_timer #(.TICK_DIV(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .load      (load),
      .load_mins (load_mins),
      .load_secs (load_secs),
      .mins_bcd  (mins_bcd),
      .secs_bcd  (secs_bcd),
      .time_up   (time_up),
      .tick      (tick),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Toggle register model: flips on a start pulse or a rising time_up.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         run_tff   <= 1'b0;
         time_up_d <= 1'b0;
      end else begin
         time_up_d <= time_up;
         if (use_loop && (start || (time_up && !time_up_d)))
            run_tff <= ~run_tff;
      end
   end

   assign run = use_loop ? run_tff : run_drv;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [7:0] m, input logic [7:0] s);
      load      = 1'b1;
      load_mins = m;
      load_secs = s;
      step(1);
      load = 1'b0;
   endtask

   initial begin
      rst = 1'b1; run_drv = 1'b0; load = 1'b0; load_mins = 8'h00; load_secs = 8'h00;
      use_loop = 1'b0; start = 1'b0;
      step(2);
      rst = 1'b0;
      step(1);
      chk("rst_mins", mins_bcd, 8'h00);
      chk("rst_secs", secs_bcd, 8'h00);
      chk("rst_tup", time_up, 1'b0);
      chk("rst_tick", tick, 1'b0);
      chk("rst_zero", zero, 1'b1);

      // Basic countdown 00:03
      run_drv = 1'b1;
      do_load(8'h00, 8'h03);
      chk("basic_load", secs_bcd, 8'h03);
      chk("basic_load_tup", time_up, 1'b0);
      begin
         logic [7:0] exp_secs [3];
         exp_secs[0] = 8'h02; exp_secs[1] = 8'h01; exp_secs[2] = 8'h00;
         for (int i = 0; i < 3; i++) begin
            step(3);
            chk("basic_hold", secs_bcd, (i == 0) ? 8'h03 : exp_secs[i-1]);
            chk("basic_notick", tick, 1'b0);
            step(1);
            chk("basic_dec", secs_bcd, exp_secs[i]);
            chk("basic_tick", tick, 1'b1);
            chk("basic_tup", time_up, (i == 2) ? 1'b1 : 1'b0);
         end
      end
      chk("basic_zero", zero, 1'b1);
      step(1);
      chk("zero_level_tup", time_up, 1'b1);
      chk("zero_tick_low", tick, 1'b0);
      step(8);
      chk("no_wrap_secs", secs_bcd, 8'h00);
      chk("no_wrap_mins", mins_bcd, 8'h00);
      run_drv = 1'b0;
      step(1);
      chk("stop_tup", time_up, 1'b0);

      // Borrow across minutes
      run_drv = 1'b1;
      do_load(8'h10, 8'h00);
      step(4);
      chk("borrow10_mins", mins_bcd, 8'h09);
      chk("borrow10_secs", secs_bcd, 8'h59);
      chk("borrow10_tick", tick, 1'b1);
      do_load(8'h01, 8'h00);
      step(4);
      chk("borrow01_mins", mins_bcd, 8'h00);
      chk("borrow01_secs", secs_bcd, 8'h59);
      chk("borrow01_tup", time_up, 1'b0);
      do_load(8'h00, 8'h20);
      step(4);
      chk("borrow_tens", secs_bcd, 8'h19);

      // Asynchronous reset mid-count at 01:30
      do_load(8'h01, 8'h30);
      step(2);
      #2 rst = 1'b1;
      #1;
      chk("arst_mins", mins_bcd, 8'h00);
      chk("arst_secs", secs_bcd, 8'h00);
      chk("arst_tick", tick, 1'b0);
      chk("arst_tup", time_up, 1'b0);
      step(1);
      rst = 1'b0;
      step(10);
      chk("arst_stay_mins", mins_bcd, 8'h00);
      chk("arst_stay_secs", secs_bcd, 8'h00);
      chk("arst_zero_tup", time_up, 1'b1);
      run_drv = 1'b0;

      // Pause preserves the partial second
      do_load(8'h00, 8'h05);
      run_drv = 1'b1;
      step(2);
      run_drv = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         chk("pause_tick", tick, 1'b0);
      end
      chk("pause_secs", secs_bcd, 8'h05);
      run_drv = 1'b1;
      step(1);
      chk("resume1_secs", secs_bcd, 8'h05);
      step(1);
      chk("resume2_secs", secs_bcd, 8'h04);
      chk("resume2_tick", tick, 1'b1);

      // Run dropping exactly when the prescaler would wrap
      do_load(8'h00, 8'h02);
      step(3);
      run_drv = 1'b0;
      step(3);
      chk("drop_secs", secs_bcd, 8'h02);
      chk("drop_tick", tick, 1'b0);
      run_drv = 1'b1;
      step(1);
      chk("drop_resume_secs", secs_bcd, 8'h01);
      chk("drop_resume_tick", tick, 1'b1);

      // Clamping and load while running
      run_drv = 1'b0;
      do_load(8'hAF, 8'h7C);
      chk("clamp_mins", mins_bcd, 8'h99);
      chk("clamp_secs", secs_bcd, 8'h59);
      run_drv = 1'b1;
      step(2);
      do_load(8'h00, 8'h02);
      chk("lwr_secs", secs_bcd, 8'h02);
      chk("lwr_tick", tick, 1'b0);
      step(3);
      chk("lwr_hold", secs_bcd, 8'h02);
      step(1);
      chk("lwr_dec", secs_bcd, 8'h01);
      chk("lwr_dec_tick", tick, 1'b1);

      // Closed loop with the toggle register at 00:00
      run_drv = 1'b0;
      do_load(8'h00, 8'h00);
      use_loop = 1'b1;
      start = 1'b1;
      step(1);
      start = 1'b0;
      chk("loop_run_on", run, 1'b1);
      chk("loop_tup0", time_up, 1'b0);
      step(1);
      chk("loop_tup1", time_up, 1'b1);
      chk("loop_run_still", run, 1'b1);
      step(1);
      chk("loop_run_off", run, 1'b0);
      step(1);
      chk("loop_tup_clear", time_up, 1'b0);
      step(3);
      chk("loop_run_stays", run, 1'b0);
      chk("loop_mins", mins_bcd, 8'h00);
      chk("loop_secs", secs_bcd, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout act=running exp=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
